// File: rtl/mem_port_arbiter.sv
// Arbiter for a single-ported unified memory shared by instruction fetch (IF)
// and the MEM stage (dm). Data side wins contention unless fetch has starved.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wen,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          st_ack_q, st_ack_d;

  logic if_win, dm_win, rd_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= OWN_IF;
      lat_q    <= '0;
      starve_q <= '0;
      st_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      st_ack_q <= st_ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    st_ack_d  = 1'b0;
    if_win    = 1'b0;
    dm_win    = 1'b0;
    rd_done   = 1'b0;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    if_stall  = 1'b0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    dm_stall  = 1'b0;
    mem_en    = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;

    // Everything is gated by reset so outputs read zero while it is held.
    if (!reset) begin
      rd_done = (state_q == WAIT) && (lat_q == LW'(1));
      if (state_q == IDLE) begin
        if_win = if_req && (!dm_req || (starve_q == SW'(STARVE_MAX)));
        dm_win = dm_req && !if_win;
      end

      if_gnt = if_win;
      dm_gnt = dm_win;
      mem_en = if_win || dm_win;
      if (if_win) begin
        mem_addr = if_addr;
      end else if (dm_win) begin
        mem_addr  = dm_addr;
        mem_wen   = dm_wen;
        mem_wdata = dm_wdata;
      end

      // Read data is a combinational pass-through in the return cycle.
      if_rvalid = rd_done && (owner_q == OWN_IF);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      dm_rvalid = (rd_done && (owner_q == OWN_DM)) || st_ack_q;
      dm_rdata  = (rd_done && (owner_q == OWN_DM)) ? mem_rdata : '0;

      if_stall = (if_req && !if_win) ||
                 ((state_q == WAIT) && (owner_q == OWN_IF) && !if_rvalid);
      dm_stall = (dm_req && !dm_win) ||
                 ((state_q == WAIT) && (owner_q == OWN_DM) && !dm_rvalid);
      busy     = (state_q == WAIT);

      unique case (state_q)
        IDLE: begin
          if (if_req && dm_win && (starve_q != SW'(STARVE_MAX)))
            starve_d = starve_q + SW'(1);
          if (if_win)
            starve_d = '0;
          // Stores complete in the grant cycle; only reads occupy the port.
          if (if_win || (dm_win && !dm_wen)) begin
            state_d = WAIT;
            owner_d = dm_win ? OWN_DM : OWN_IF;
            lat_d   = LW'(MEM_LAT);
          end
          st_ack_d = dm_win && dm_wen;
        end
        WAIT: begin
          lat_d = lat_q - LW'(1);
          if (rd_done)
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
